id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register for the superscalar core, generalised from the fixed dual-issue version to LANES issue slots. It adds per-lane valid bits, a ready/valid bundle handshake with downstream backpressure, and a pipeline flush. All lanes of an issue bundle move together as one unit. It sits between decode/register-read and the execute lanes.

Parameters:
LANES, 2, number of issue lanes per bundle (1..8)
XLEN, 32, data/PC width
REGW, 5, register index width
ALUOPW, 4, ALU opcode width

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  kill the held bundle and drop the input bundle (branch mispredict/trap)
in_valid  in  LANES  per-lane valid of the incoming bundle
in_ready  out  1  stage accepts a bundle this cycle
in_pc, in_rs1, in_rs2, in_imm  in  LANES*XLEN each  lane i at bits [i*XLEN +: XLEN]
in_rd  in  LANES*REGW  destination register per lane
in_alu_op  in  LANES*ALUOPW  ALU opcode per lane
in_is_mem, in_is_store  in  LANES each  memory op / store flags
out_valid  out  LANES  per-lane valid of the held bundle
out_ready  in  1  execute accepts the held bundle
out_pc, out_rs1, out_rs2, out_imm, out_rd, out_alu_op, out_is_mem, out_is_store  out  same widths as inputs  registered payload

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Definitions: in_fire = |in_valid & in_ready. out_fire = |out_valid & out_ready. full = |out_valid.
- Reset: all out_* including out_valid are 0. in_ready is 0 while reset is high and 1 in the first cycle after it is released.
- in_ready, base build: combinational, equal to !reset & !flush & (!full | out_ready).
- Load: on in_fire, every lane register takes its input in the same edge, so latency is 1 cycle.
- Invalid lanes: a lane with in_valid[i]=0 loads a zero payload. This means rd=0, is_mem=0 and is_store=0, so forwarding and hazard logic never see stale rd values.
- Drain: on out_fire with no in_fire, out_valid becomes 0 and the payload holds its last value.
- Simultaneous out_fire and in_fire: the new bundle replaces the old one with no bubble, giving 1 bundle/cycle throughput.
- Backpressure: when full and out_ready=0, all outputs hold and in_ready=0.
- Flush: highest priority after reset. The next state has out_valid=0 and the payload zeroed. The input bundle in that cycle is not accepted, since in_ready=0.
- Bundle with in_valid all 0: never fires. The register state is unchanged unless out_fire occurs.
- is_store is only meaningful when is_mem is set. The stage passes both flags unmodified and does not check them.

Optional Feature:
IDEX_SKID_EN
- Defined: adds a one-bundle skid buffer so in_ready is a registered output, equal to "skid empty", with no combinational path from out_ready.
  - If the stage is full, out_ready=0 and in_fire occurs, the bundle goes to the skid.
  - When the main bundle fires, the skid moves into the main register in the same edge.
  - While the skid is empty, behaviour matches the base build.
  - flush and reset clear both entries.
  - Bundle order is preserved.
- Undefined: no skid storage exists and in_ready is combinational as described above.

Test Plan:
1. Reset, then in_valid=2'b11, pc={0x104,0x100}, rd={7,3}, out_ready=1 -> next cycle out_valid=2'b11, out_pc={0x104,0x100}, out_rd={7,3}. in_ready stays 1 throughout.
2. in_valid=2'b01, lane1 rd=9, is_store=1 -> out_valid=2'b01, lane1 out_rd=0, out_is_store=0.
3. Full stage, out_ready=0 for 3 cycles with a new in_valid=2'b11 -> outputs unchanged and in_ready=0. With IDEX_SKID_EN, one bundle is accepted into the skid, then in_ready=0. The original bundle emerges before the skidded one.
4. Back-to-back bundles PC 0x200, 0x208, 0x210 with out_ready=1 -> one bundle per cycle on the output, in order, with no bubbles.
5. flush high with a full stage and in_valid=2'b11 -> next cycle out_valid=0, payload 0, and the input bundle is not seen on the output later.
6. reset asserted mid-stream while full and stalled -> next cycle all outputs 0 and the skid is empty. in_ready is 1 the cycle after reset is released.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for LANES issue slots with a bundle-level ready/valid handshake and flush.
// Define IDEX_SKID_EN to add a one-bundle skid buffer, which makes in_ready independent of out_ready.
module id_ex_pipe_reg #(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter int ALUOPW = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  output logic                    in_ready,
  input  logic [LANES*XLEN-1:0]   in_pc,
  input  logic [LANES*XLEN-1:0]   in_rs1,
  input  logic [LANES*XLEN-1:0]   in_rs2,
  input  logic [LANES*XLEN-1:0]   in_imm,
  input  logic [LANES*REGW-1:0]   in_rd,
  input  logic [LANES*ALUOPW-1:0] in_alu_op,
  input  logic [LANES-1:0]        in_is_mem,
  input  logic [LANES-1:0]        in_is_store,
  output logic [LANES-1:0]        out_valid,
  input  logic                    out_ready,
  output logic [LANES*XLEN-1:0]   out_pc,
  output logic [LANES*XLEN-1:0]   out_rs1,
  output logic [LANES*XLEN-1:0]   out_rs2,
  output logic [LANES*XLEN-1:0]   out_imm,
  output logic [LANES*REGW-1:0]   out_rd,
  output logic [LANES*ALUOPW-1:0] out_alu_op,
  output logic [LANES-1:0]        out_is_mem,
  output logic [LANES-1:0]        out_is_store
);

  typedef struct packed {
    logic [LANES*XLEN-1:0]   pc;
    logic [LANES*XLEN-1:0]   rs1;
    logic [LANES*XLEN-1:0]   rs2;
    logic [LANES*XLEN-1:0]   imm;
    logic [LANES*REGW-1:0]   rd;
    logic [LANES*ALUOPW-1:0] alu_op;
    logic [LANES-1:0]        is_mem;
    logic [LANES-1:0]        is_store;
  } bundle_t;

  bundle_t          w_in_masked;
  bundle_t          r_main;
  logic [LANES-1:0] r_valid;
  logic             w_full;
  logic             w_out_fire;
  logic             w_in_fire;

  // Invalid lanes carry an all-zero payload so hazard logic never sees a stale rd.
  always_comb begin
    w_in_masked = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        w_in_masked.pc[i*XLEN +: XLEN]         = in_pc[i*XLEN +: XLEN];
        w_in_masked.rs1[i*XLEN +: XLEN]        = in_rs1[i*XLEN +: XLEN];
        w_in_masked.rs2[i*XLEN +: XLEN]        = in_rs2[i*XLEN +: XLEN];
        w_in_masked.imm[i*XLEN +: XLEN]        = in_imm[i*XLEN +: XLEN];
        w_in_masked.rd[i*REGW +: REGW]         = in_rd[i*REGW +: REGW];
        w_in_masked.alu_op[i*ALUOPW +: ALUOPW] = in_alu_op[i*ALUOPW +: ALUOPW];
        w_in_masked.is_mem[i]                  = in_is_mem[i];
        w_in_masked.is_store[i]                = in_is_store[i];
      end
    end
  end

  assign w_full     = |r_valid;
  assign w_out_fire = w_full & out_ready;
  assign w_in_fire  = (|in_valid) & in_ready;

`ifdef IDEX_SKID_EN
  bundle_t          r_skid;
  logic [LANES-1:0] r_skid_valid;

  // Ready depends only on skid occupancy plus reset/flush gating, never on out_ready.
  assign in_ready = !reset & !flush & !(|r_skid_valid);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid      <= '0;
      r_main       <= '0;
      r_skid_valid <= '0;
      r_skid       <= '0;
    end else if (w_in_fire && (!w_full || out_ready)) begin
      r_valid <= in_valid;
      r_main  <= w_in_masked;
    end else if (w_in_fire) begin
      r_skid_valid <= in_valid;
      r_skid       <= w_in_masked;
    end else if (w_out_fire) begin
      r_valid <= r_skid_valid;
      if (|r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= '0;
        r_skid       <= '0;
      end
    end
  end
`else
  assign in_ready = !reset & !flush & (!w_full | out_ready);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= '0;
      r_main  <= '0;
    end else if (w_in_fire) begin
      r_valid <= in_valid;
      r_main  <= w_in_masked;
    end else if (w_out_fire) begin
      r_valid <= '0;
    end
  end
`endif

  assign out_valid    = r_valid;
  assign out_pc       = r_main.pc;
  assign out_rs1      = r_main.rs1;
  assign out_rs2      = r_main.rs2;
  assign out_imm      = r_main.imm;
  assign out_rd       = r_main.rd;
  assign out_alu_op   = r_main.alu_op;
  assign out_is_mem   = r_main.is_mem;
  assign out_is_store = r_main.is_store;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg (default build): directed vector table, then random traffic vs a lane-array model.
module tb_id_ex_pipe_reg;
  localparam int L = 2;
  localparam int X = 32;
  localparam int R = 5;
  localparam int A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, flush, in_ready, out_ready;
  logic [L-1:0]   in_valid, out_valid;
  logic [L*X-1:0] in_pc, in_rs1, in_rs2, in_imm, out_pc, out_rs1, out_rs2, out_imm;
  logic [L*R-1:0] in_rd, out_rd;
  logic [L*A-1:0] in_alu_op, out_alu_op;
  logic [L-1:0]   in_is_mem, in_is_store, out_is_mem, out_is_store;

  id_ex_pipe_reg #(.LANES(L), .XLEN(X), .REGW(R), .ALUOPW(A)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .in_alu_op(in_alu_op), .in_is_mem(in_is_mem), .in_is_store(in_is_store),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_rd(out_rd), .out_alu_op(out_alu_op),
    .out_is_mem(out_is_mem), .out_is_store(out_is_store)
  );

  int checks = 0;
  int errors = 0;

  // Per-lane stimulus values
  logic [X-1:0] p_pc[L], p_rs1[L], p_rs2[L], p_imm[L];
  logic [R-1:0] p_rd[L];
  logic [A-1:0] p_alu[L];
  logic         p_mem[L], p_st[L];

  // Reference model: the held bundle as per-lane arrays
  logic [L-1:0] m_v;
  logic [X-1:0] m_pc[L], m_rs1[L], m_rs2[L], m_imm[L];
  logic [R-1:0] m_rd[L];
  logic [A-1:0] m_alu[L];
  logic         m_mem[L], m_st[L];

  typedef struct {
    logic         rst, fl;
    logic [1:0]   v;
    logic         ordy;
    logic [31:0]  pc0, pc1;
    logic [4:0]   rd0, rd1;
    logic         st1;
    logic         eir;
    logic [1:0]   ev;
    logic [31:0]  epc0, epc1;
    logic [4:0]   erd0, erd1;
    logic         est1;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic rst, input logic fl, input logic [1:0] v, input logic ordy,
                              input logic [31:0] pc0, input logic [31:0] pc1, input logic [4:0] rd0,
                              input logic [4:0] rd1, input logic st1, input logic eir, input logic [1:0] ev,
                              input logic [31:0] epc0, input logic [31:0] epc1, input logic [4:0] erd0,
                              input logic [4:0] erd1, input logic est1);
    vec_t t;
    t.rst = rst; t.fl = fl; t.v = v; t.ordy = ordy; t.pc0 = pc0; t.pc1 = pc1;
    t.rd0 = rd0; t.rd1 = rd1; t.st1 = st1; t.eir = eir; t.ev = ev; t.epc0 = epc0;
    t.epc1 = epc1; t.erd0 = erd0; t.erd1 = erd1; t.est1 = est1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < L; i++) begin
      in_pc[i*X +: X]     = p_pc[i];
      in_rs1[i*X +: X]    = p_rs1[i];
      in_rs2[i*X +: X]    = p_rs2[i];
      in_imm[i*X +: X]    = p_imm[i];
      in_rd[i*R +: R]     = p_rd[i];
      in_alu_op[i*A +: A] = p_alu[i];
      in_is_mem[i]        = p_mem[i];
      in_is_store[i]      = p_st[i];
    end
  endtask

  function automatic logic model_ready();
    return !reset && !flush && (m_v == '0 || out_ready);
  endfunction

  task automatic model_step(input logic rdy);
    if (reset || flush) begin
      m_v = '0;
      for (int i = 0; i < L; i++) begin
        m_pc[i] = '0; m_rs1[i] = '0; m_rs2[i] = '0; m_imm[i] = '0;
        m_rd[i] = '0; m_alu[i] = '0; m_mem[i] = 1'b0; m_st[i] = 1'b0;
      end
    end else if (in_valid != '0 && rdy) begin
      m_v = in_valid;
      for (int i = 0; i < L; i++) begin
        m_pc[i]  = in_valid[i] ? p_pc[i]  : '0;
        m_rs1[i] = in_valid[i] ? p_rs1[i] : '0;
        m_rs2[i] = in_valid[i] ? p_rs2[i] : '0;
        m_imm[i] = in_valid[i] ? p_imm[i] : '0;
        m_rd[i]  = in_valid[i] ? p_rd[i]  : '0;
        m_alu[i] = in_valid[i] ? p_alu[i] : '0;
        m_mem[i] = in_valid[i] ? p_mem[i] : 1'b0;
        m_st[i]  = in_valid[i] ? p_st[i]  : 1'b0;
      end
    end else if (m_v != '0 && out_ready) begin
      m_v = '0;
    end
  endtask

  task automatic check_model();
    chk("out_valid", 64'(out_valid), 64'(m_v));
    for (int i = 0; i < L; i++) begin
      chk($sformatf("pc[%0d]", i),       64'(out_pc[i*X +: X]),     64'(m_pc[i]));
      chk($sformatf("rs1[%0d]", i),      64'(out_rs1[i*X +: X]),    64'(m_rs1[i]));
      chk($sformatf("rs2[%0d]", i),      64'(out_rs2[i*X +: X]),    64'(m_rs2[i]));
      chk($sformatf("imm[%0d]", i),      64'(out_imm[i*X +: X]),    64'(m_imm[i]));
      chk($sformatf("rd[%0d]", i),       64'(out_rd[i*R +: R]),     64'(m_rd[i]));
      chk($sformatf("alu_op[%0d]", i),   64'(out_alu_op[i*A +: A]), 64'(m_alu[i]));
      chk($sformatf("is_mem[%0d]", i),   64'(out_is_mem[i]),        64'(m_mem[i]));
      chk($sformatf("is_store[%0d]", i), 64'(out_is_store[i]),      64'(m_st[i]));
    end
  endtask

  initial begin
    logic rdy;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = '0;
    for (int i = 0; i < L; i++) begin
      p_pc[i] = '0; p_rs1[i] = '0; p_rs2[i] = '0; p_imm[i] = '0;
      p_rd[i] = '0; p_alu[i] = '0; p_mem[i] = 1'b0; p_st[i] = 1'b0;
    end
    drive();
    m_v = '0;
    for (int i = 0; i < L; i++) begin
      m_pc[i] = '0; m_rs1[i] = '0; m_rs2[i] = '0; m_imm[i] = '0;
      m_rd[i] = '0; m_alu[i] = '0; m_mem[i] = 1'b0; m_st[i] = 1'b0;
    end

    //         rst   fl    v      ordy  pc0           pc1           rd0    rd1    st1   eir   ev     epc0          epc1          erd0   erd1   est1
    tbl[0]  = mk(1'b1, 1'b0, 2'b11, 1'b1, 32'h100, 32'h104, 5'd3,  5'd7,  1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   5'd0,  5'd0,  1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 2'b11, 1'b1, 32'h100, 32'h104, 5'd3,  5'd7,  1'b0, 1'b1, 2'b11, 32'h100, 32'h104, 5'd3,  5'd7,  1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 2'b01, 1'b1, 32'h110, 32'h114, 5'd4,  5'd9,  1'b1, 1'b1, 2'b01, 32'h110, 32'h0,   5'd4,  5'd0,  1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h120, 32'h124, 5'd5,  5'd6,  1'b0, 1'b0, 2'b01, 32'h110, 32'h0,   5'd4,  5'd0,  1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h120, 32'h124, 5'd5,  5'd6,  1'b0, 1'b0, 2'b01, 32'h110, 32'h0,   5'd4,  5'd0,  1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h120, 32'h124, 5'd5,  5'd6,  1'b0, 1'b0, 2'b01, 32'h110, 32'h0,   5'd4,  5'd0,  1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 2'b11, 1'b1, 32'h200, 32'h204, 5'd1,  5'd2,  1'b0, 1'b1, 2'b11, 32'h200, 32'h204, 5'd1,  5'd2,  1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 2'b11, 1'b1, 32'h208, 32'h20c, 5'd3,  5'd4,  1'b0, 1'b1, 2'b11, 32'h208, 32'h20c, 5'd3,  5'd4,  1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 2'b11, 1'b1, 32'h210, 32'h214, 5'd5,  5'd6,  1'b0, 1'b1, 2'b11, 32'h210, 32'h214, 5'd5,  5'd6,  1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 32'h2f0, 32'h2f4, 5'd11, 5'd12, 1'b0, 1'b1, 2'b00, 32'h210, 32'h214, 5'd5,  5'd6,  1'b0);
    tbl[10] = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h300, 32'h304, 5'd8,  5'd9,  1'b0, 1'b1, 2'b11, 32'h300, 32'h304, 5'd8,  5'd9,  1'b0);
    tbl[11] = mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h400, 32'h404, 5'd10, 5'd11, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   5'd0,  5'd0,  1'b0);
    tbl[12] = mk(1'b0, 1'b0, 2'b00, 1'b1, 32'h400, 32'h404, 5'd10, 5'd11, 1'b0, 1'b1, 2'b00, 32'h0,   32'h0,   5'd0,  5'd0,  1'b0);
    tbl[13] = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h500, 32'h504, 5'd12, 5'd13, 1'b0, 1'b1, 2'b11, 32'h500, 32'h504, 5'd12, 5'd13, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h600, 32'h604, 5'd14, 5'd15, 1'b0, 1'b0, 2'b11, 32'h500, 32'h504, 5'd12, 5'd13, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h600, 32'h604, 5'd14, 5'd15, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   5'd0,  5'd0,  1'b0);
    tbl[16] = mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h700, 32'h704, 5'd16, 5'd17, 1'b0, 1'b1, 2'b00, 32'h0,   32'h0,   5'd0,  5'd0,  1'b0);

    @(posedge clk); #1;
    for (int n = 0; n < 17; n++) begin
      reset = tbl[n].rst; flush = tbl[n].fl; in_valid = tbl[n].v; out_ready = tbl[n].ordy;
      p_pc[0] = tbl[n].pc0; p_pc[1] = tbl[n].pc1; p_rd[0] = tbl[n].rd0; p_rd[1] = tbl[n].rd1;
      for (int i = 0; i < L; i++) begin
        p_rs1[i] = p_pc[i] + 32'd1; p_rs2[i] = p_pc[i] + 32'd2; p_imm[i] = p_pc[i] + 32'd3;
        p_alu[i] = p_rd[i][3:0];
      end
      p_st[0] = 1'b0; p_mem[0] = 1'b0; p_st[1] = tbl[n].st1; p_mem[1] = tbl[n].st1;
      drive();
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", n), 64'(in_ready), 64'(tbl[n].eir));
      rdy = model_ready();
      @(posedge clk); #1;
      model_step(rdy);
      chk($sformatf("vec%0d out_valid", n), 64'(out_valid),           64'(tbl[n].ev));
      chk($sformatf("vec%0d pc0", n),       64'(out_pc[31:0]),        64'(tbl[n].epc0));
      chk($sformatf("vec%0d pc1", n),       64'(out_pc[63:32]),       64'(tbl[n].epc1));
      chk($sformatf("vec%0d rd0", n),       64'(out_rd[4:0]),         64'(tbl[n].erd0));
      chk($sformatf("vec%0d rd1", n),       64'(out_rd[9:5]),         64'(tbl[n].erd1));
      chk($sformatf("vec%0d store1", n),    64'(out_is_store[1]),     64'(tbl[n].est1));
    end

    // Random traffic against the model, including occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      in_valid  = L'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < L; i++) begin
        p_pc[i] = $urandom; p_rs1[i] = $urandom; p_rs2[i] = $urandom; p_imm[i] = $urandom;
        p_rd[i] = R'($urandom); p_alu[i] = A'($urandom);
        p_mem[i] = 1'($urandom); p_st[i] = 1'($urandom);
      end
      drive();
      @(negedge clk);
      rdy = model_ready();
      chk("rnd in_ready", 64'(in_ready), 64'(rdy));
      @(posedge clk); #1;
      model_step(rdy);
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
